// File: rtl/tdm_demux4.sv
// ---------------------------------------------------------------------------
// tdm_demux4
//
// Receive end of a 1-bit, four-slot TDM link. Frame alignment comes from a
// one-cycle frame_sync pulse marking cycle 0 of slot 0. Once enough
// consecutive frame syncs arrive on time, the block declares lock. It then
// samples line_in in the middle of every slot and routes each sample to a
// per-channel registered output with a one-cycle valid strobe.
//
// Parameters:
//   SLOT_CYCLES  clock cycles per slot (2..256); a frame is 4*SLOT_CYCLES.
//   LOCK_FRAMES  consecutive on-time syncs needed to declare lock (1..15).
//
// Ports:
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   line_in     TDM serial data, slot order 0,1,2,3
//   frame_sync  one-cycle pulse on cycle 0 of slot 0
//   ch_out      bit k = last captured sample of slot k
//   valid       bit k pulses for one cycle when ch_out[k] updates
//   slot_idx    current slot counter
//   locked      high while the link is locked
//   sync_err    one-cycle pulse on loss or misalignment while locked
// ---------------------------------------------------------------------------
module tdm_demux4 #(
    parameter int SLOT_CYCLES = 4,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       line_in,
    input  logic       frame_sync,
    output logic [3:0] ch_out,
    output logic [3:0] valid,
    output logic [1:0] slot_idx,
    output logic       locked,
    output logic       sync_err
);

    localparam int            CW          = $clog2(SLOT_CYCLES);
    localparam logic [CW-1:0] CYC_LAST    = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] CYC_MID     = CW'(SLOT_CYCLES / 2);
    localparam logic [CW-1:0] CYC_ONE     = CW'(1);
    localparam logic [3:0]    GOOD_TARGET = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LOCKING = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [1:0]    slot_q, slot_d;
    logic [3:0]    good_q, good_d;
    logic          err_d;
    logic          at_start;
    logic          capture;

    // Outside HUNT the counters only read slot 0 / cycle 0 immediately after
    // a frame wrap. A sync always reloads them to cycle 1, so this is exactly
    // the cycle on which the next frame sync is due.
    assign at_start = (cyc_q == '0) && (slot_q == 2'd0);

    // A slot is sampled at its midpoint, but only while the link stays locked
    // through this cycle. A sync that knocks the link out of lock suppresses
    // the sample, so valid is never seen outside the locked state.
    assign capture = (state_q == ST_LOCKED) && !frame_sync && (cyc_q == CYC_MID);

    assign slot_idx = slot_q;
    assign locked   = (state_q == ST_LOCKED);

    // Next-state logic for the alignment FSM and the slot counters. A
    // frame_sync always realigns the counters and takes priority over the
    // natural counter wrap in the same cycle.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_d   = 1'b0;
        if (cyc_q == CYC_LAST) begin
            cyc_d  = '0;
            slot_d = slot_q + 2'd1;
        end else begin
            cyc_d  = cyc_q + CYC_ONE;
            slot_d = slot_q;
        end

        case (state_q)
            ST_HUNT: begin
                cyc_d  = '0;
                slot_d = 2'd0;
                good_d = 4'd0;
                if (frame_sync) begin
                    state_d = ST_LOCKING;
                    cyc_d   = CYC_ONE;
                end
            end

            ST_LOCKING: begin
                if (frame_sync) begin
                    cyc_d  = CYC_ONE;
                    slot_d = 2'd0;
                    if (at_start) begin
                        if (good_q + 4'd1 == GOOD_TARGET) begin
                            state_d = ST_LOCKED;
                            good_d  = 4'd0;
                        end else begin
                            good_d = good_q + 4'd1;
                        end
                    end else begin
                        good_d = 4'd0;
                    end
                end else if (at_start) begin
                    state_d = ST_HUNT;
                    cyc_d   = '0;
                    slot_d  = 2'd0;
                    good_d  = 4'd0;
                end
            end

            ST_LOCKED: begin
                if (frame_sync) begin
                    cyc_d  = CYC_ONE;
                    slot_d = 2'd0;
                    if (!at_start) begin
                        state_d = ST_LOCKING;
                        good_d  = 4'd0;
                        err_d   = 1'b1;
                    end
                end else if (at_start) begin
                    state_d = ST_HUNT;
                    cyc_d   = '0;
                    slot_d  = 2'd0;
                    good_d  = 4'd0;
                    err_d   = 1'b1;
                end
            end

            default: begin
                state_d = ST_HUNT;
                cyc_d   = '0;
                slot_d  = 2'd0;
                good_d  = 4'd0;
            end
        endcase
    end

    // FSM state, slot counters and the error strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_HUNT;
            cyc_q    <= '0;
            slot_q   <= 2'd0;
            good_q   <= 4'd0;
            sync_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            slot_q   <= slot_d;
            good_q   <= good_d;
            sync_err <= err_d;
        end
    end

    // Per-channel sample registers. Only the channel of the current slot is
    // written; the others hold, including across loss of lock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch_out <= 4'd0;
            valid  <= 4'd0;
        end else begin
            valid <= 4'd0;
            if (capture) begin
                ch_out[slot_q] <= line_in;
                valid[slot_q]  <= 1'b1;
            end
        end
    end

endmodule
